gsim_result_buf: RTL and testbench
==================================

GSIM_RESULT_BUF -- requirements
Module: gsim_result_buf

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the number of solution words per burst.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port x_valid, input, 1 bit, solver out_valid, high for N consecutive cycles per burst.
REQ-005 The block SHALL have port x_in, input, 32 bits, solver x_out in Q16.16 two's complement.
REQ-006 The block SHALL have port o_valid, output, 1 bit, which is high while o_data holds a valid word.
REQ-007 The block SHALL have port o_ready, input, 1 bit, the downstream accept signal.
REQ-008 The block SHALL have port o_data, output, 32 bits, the buffered word.
REQ-009 The block SHALL have port o_idx, output, 4 bits, the index (0..N-1) of o_data.
REQ-010 The block SHALL have port o_last, output, 1 bit, which is high with o_valid when o_idx==N-1.
REQ-011 The block SHALL have port busy, output, 1 bit, which is high in CAPTURE or DRAIN.
REQ-012 The block SHALL have port err, output, 1 bit, a sticky error flag for a dropped or truncated burst.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CAPTURE and DRAIN, using an N-entry 32-bit buffer and a write pointer and read pointer of $clog2(N) bits each.
REQ-014 In IDLE, x_valid=1 SHALL store x_in at entry 0, set wptr=1 and move the FSM to CAPTURE.
REQ-015 In CAPTURE, each x_valid=1 cycle SHALL store x_in at entry wptr and increment wptr.
REQ-016 Storing entry N-1 SHALL move the FSM to DRAIN with rptr=0 on the next cycle.
REQ-017 In CAPTURE, x_valid=0 before N words (truncated burst) SHALL set err, discard the partial data, and return the FSM to IDLE.
REQ-018 In DRAIN, the block SHALL hold o_valid=1, o_data=processed buffer[rptr] and o_idx=rptr.
REQ-019 A transfer SHALL occur in any cycle with o_valid&&o_ready, and each transfer SHALL increment rptr.
REQ-020 A transfer with rptr==N-1 SHALL return the FSM to IDLE with o_valid=0 on the next cycle.
REQ-021 While o_valid=1 and o_ready=0, o_data, o_idx and o_last SHALL be held stable.
REQ-022 Latency SHALL be as follows: o_valid rises exactly 1 cycle after the cycle in which word N-1 is captured.
REQ-023 A burst of N words with o_ready held high SHALL complete in 2N+1 cycles from the first x_valid.
REQ-024 x_valid=1 during DRAIN SHALL be ignored, SHALL set err, and SHALL leave the buffer and the drain unaffected.
REQ-025 In IDLE, o_valid, o_last and busy SHALL be 0, and o_data and o_idx SHALL be 0.
REQ-026 err SHALL stay set until reset.

Reset
REQ-027 reset=1 at a clock edge SHALL set: state IDLE; wptr=0; rptr=0; o_valid=0; o_data=0; o_idx=0; o_last=0; busy=0; err=0.
REQ-028 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the burst with no further o_valid.
REQ-029 Buffer contents need not be cleared on reset.
REQ-030 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-031 With macro GSIM_RBUF_SAT16_EN defined, o_data SHALL be the rounded, saturated integer part of the stored word, sign-extended to 32 bits.
REQ-032 The GSIM_RBUF_SAT16_EN conversion SHALL be: round = (x + 32'h0000_8000) arithmetic-shifted right 16 (the add is computed in 33 bits); the result is clamped to [-32768, 32767].
REQ-033 With GSIM_RBUF_SAT16_EN undefined, o_data SHALL be the raw stored Q16.16 word.
REQ-034 The conversion SHALL be purely combinational on the read path, so latency is the same with and without the macro.

Structure
REQ-035 A shared package gsim_pkg SHALL hold: the state enum type (IDLE/CAPTURE/DRAIN), the constant GSIM_N=16, the Q16.16 fraction width GSIM_FRAC=16, and the saturation limits.
REQ-036 The sub-module gsim_sat16 SHALL hold the round/saturate function and SHALL be instantiated only when GSIM_RBUF_SAT16_EN is defined.

Verification
REQ-037 Bench scenario: x_valid high 16 cycles with x_in=k<<16 (k=0..15) and o_ready=1 -> 16 transfers with o_idx 0..15, o_data equal to the inputs, o_last only on idx 15, then IDLE.
REQ-038 Bench scenario: same burst with o_ready toggling 1,0,1,0 -> o_data is held stable during stalls, all 16 words arrive in order, and busy drops after idx 15.
REQ-039 Bench scenario: x_valid high only 7 cycles -> err=1, no o_valid, FSM back in IDLE, and a following full burst drains correctly.
REQ-040 Bench scenario: x_valid pulsed during DRAIN -> err=1, and the drained data is unchanged from the captured burst.
REQ-041 Bench scenario: reset asserted at capture word 9 -> all outputs are 0 on the next cycle, and a new burst then works normally.
REQ-042 Bench scenario (with GSIM_RBUF_SAT16_EN): inputs 32'h0001_8000, 32'hFFFE_8000, 32'h7FFF_FFFF, 32'h8000_0000 -> o_data 2, -1, 32767, -32768 respectively.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared definitions for the solver result buffer: burst size, Q16.16
// fraction width, 16-bit saturation limits and the buffer FSM states.
package gsim_pkg;

    localparam int GSIM_N       = 16;
    localparam int GSIM_FRAC    = 16;
    localparam int GSIM_SAT_MAX = 32767;
    localparam int GSIM_SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } gsim_state_e;

endpackage

// File: rtl/gsim_sat16.sv
// Rounds a Q16.16 word to the nearest integer (half rounds toward +inf)
// and clamps it into the signed 16-bit range, sign-extended to 32 bits.
// Only instantiated when GSIM_RBUF_SAT16_EN is defined.
module gsim_sat16
    import gsim_pkg::*;
(
    input  logic [31:0] x_in,
    output logic [31:0] y_out
);

    logic signed [32:0] sum;
    logic signed [32:0] shifted;

    // Add one half in 33 bits so the largest positive input cannot wrap, then
    // drop the fraction and clamp to the 16-bit limits.
    always_comb begin
        sum     = $signed({x_in[31], x_in}) + 33'sd32768;
        shifted = sum >>> GSIM_FRAC;
        if (shifted > $signed(33'(GSIM_SAT_MAX))) begin
            y_out = 32'(GSIM_SAT_MAX);
        end else if (shifted < $signed(33'(GSIM_SAT_MIN))) begin
            y_out = 32'(GSIM_SAT_MIN);
        end else begin
            y_out = shifted[31:0];
        end
    end

endmodule

// File: rtl/gsim_result_buf.sv
// Result buffer between the solver and a ready/valid consumer. Captures one
// burst of N Q16.16 words, then drains them in order with backpressure.
// A truncated burst or a new word arriving mid-drain sets a sticky err.
// Optional macro GSIM_RBUF_SAT16_EN: present each word as a rounded,
// saturated 16-bit integer instead of the raw Q16.16 value.
module gsim_result_buf
    import gsim_pkg::*;
#(
    parameter int N = GSIM_N
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [31:0] x_in,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    output logic [3:0]  o_idx,
    output logic        o_last,
    output logic        busy,
    output logic        err
);

    localparam int             AW       = $clog2(N);
    localparam logic [AW-1:0]  LAST_IDX = AW'(N - 1);

    gsim_state_e   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          err_q, err_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   buf_q [N];
    logic [31:0]   rd_word;
    logic [31:0]   proc_word;
    logic          draining;

    // Next-state logic: capture sequencing, drain sequencing and error detection.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = wptr_q;
        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wptr_d  = AW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (x_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = wptr_q;
                    if (wptr_q == LAST_IDX) begin
                        wptr_d  = '0;
                        rptr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        wptr_d = wptr_q + AW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    wptr_d  = '0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (x_valid) begin
                    err_d = 1'b1;
                end
                if (o_ready) begin
                    if (rptr_q == LAST_IDX) begin
                        rptr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        rptr_d = rptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wptr_d  = '0;
                rptr_d  = '0;
            end
        endcase
    end

    // Control registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buf_q[wr_addr] <= x_in;
        end
    end

    assign rd_word = buf_q[rptr_q];

`ifdef GSIM_RBUF_SAT16_EN
    gsim_sat16 u_sat16 (
        .x_in  (rd_word),
        .y_out (proc_word)
    );
`else
    assign proc_word = rd_word;
`endif

    // Outputs come straight from state so they read zero whenever idle.
    always_comb begin
        draining = (state_q == DRAIN);
        o_valid  = draining;
        o_data   = draining ? proc_word : '0;
        o_idx    = draining ? 4'(rptr_q) : 4'd0;
        o_last   = draining && (rptr_q == LAST_IDX);
        busy     = (state_q != IDLE);
        err      = err_q;
    end

endmodule

// File: tb/tb_gsim_result_buf.sv
// Self-checking bench for gsim_result_buf. Stimulus pushes expected words
// into a scoreboard queue; a negedge monitor pops and compares on every
// transfer and checks that stalled outputs stay stable.
// Build with GSIM_RBUF_SAT16_EN defined to exercise the saturating path.
module tb_gsim_result_buf;
    import gsim_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [31:0] x_in;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [3:0]  o_idx;
    logic        o_last;
    logic        busy;
    logic        err;

    gsim_result_buf #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_valid (x_valid),
        .x_in    (x_in),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [31:0] stim_words [N];

    logic        stalled = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;
    logic        held_last;

    // Reference conversion from the word format rules, done with integer math.
    function automatic logic [31:0] ref_conv(input logic [31:0] x);
`ifdef GSIM_RBUF_SAT16_EN
        longint v;
        v = longint'($signed(x)) + 64'sd32768;
        v = v >>> 16;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 32'(v);
`else
        return x;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a burst of len words; reset is raised on word reset_at (if >= 0).
    // A complete, un-reset burst queues its expected drain words.
    task automatic applyStimulus(input int len, input int reset_at);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            x_valid = 1'b1;
            x_in    = stim_words[i];
            if (i == reset_at) reset = 1'b1;
            tick();
        end
        x_valid = 1'b0;
        x_in    = '0;
        if (len == N && reset_at < 0) begin
            for (int i = 0; i < N; i++) begin
                e.data = ref_conv(stim_words[i]);
                e.idx  = 4'(i);
                e.last = (i == N - 1);
                exp_q.push_back(e);
            end
            checkOutput("latency_o_valid", 32'(o_valid), 32'd1);
        end
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        checkOutput("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
        checkOutput("idle_o_valid", 32'(o_valid), 32'd0);
        checkOutput("idle_o_data", o_data, 32'd0);
        checkOutput("idle_o_idx", 32'(o_idx), 32'd0);
        checkOutput("idle_o_last", 32'(o_last), 32'd0);
    endtask

    task automatic random_words();
        for (int i = 0; i < N; i++) stim_words[i] = $urandom;
    endtask

    // Downstream ready: 0 = always high, 1 = toggle each cycle, else random.
    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       o_ready = 1'b1;
                1:       o_ready = ~o_ready;
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: score each transfer and verify stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else if (o_valid) begin
                if (stalled) begin
                    checkOutput("stall_data", o_data, held_data);
                    checkOutput("stall_idx", 32'(o_idx), 32'(held_idx));
                    checkOutput("stall_last", 32'(o_last), 32'(held_last));
                end
                checkOutput("busy_in_drain", 32'(busy), 32'd1);
                if (o_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word actual idx=%0d data=%h required no transfer",
                                 o_idx, o_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("xfer_data", o_data, e.data);
                        checkOutput("xfer_idx", 32'(o_idx), 32'(e.idx));
                        checkOutput("xfer_last", 32'(o_last), 32'(e.last));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = o_data;
                    held_idx  = o_idx;
                    held_last = o_last;
                end
            end else begin
                if (stalled) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL valid_dropped actual o_valid=0 required 1 while stalled");
                end
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        tick();
        tick();
        checkOutput("rst_o_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_o_data", o_data, 32'd0);
        checkOutput("rst_o_idx", 32'(o_idx), 32'd0);
        checkOutput("rst_o_last", 32'(o_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Ramp burst, always ready: exact 2N+1 cycle completion.
        $display("[TB] ramp burst, ready high");
        ready_mode = 0;
        for (int k = 0; k < N; k++) stim_words[k] = 32'(k) << 16;
        applyStimulus(N, -1);
        repeat (N - 1) tick();
        checkOutput("ramp_last_busy", 32'(busy), 32'd1);
        checkOutput("ramp_last_o_last", 32'(o_last), 32'd1);
        checkOutput("ramp_last_idx", 32'(o_idx), 32'd15);
        tick();
        checkOutput("ramp_done_busy", 32'(busy), 32'd0);
        checkOutput("ramp_done_o_valid", 32'(o_valid), 32'd0);

        // Same ramp with ready toggling.
        $display("[TB] ramp burst, ready toggling");
        ready_mode = 1;
        applyStimulus(N, -1);
        wait_drain(200);
        checkOutput("toggle_err", 32'(err), 32'd0);

        // Truncated burst, then a full random burst.
        $display("[TB] truncated burst");
        ready_mode = 0;
        random_words();
        applyStimulus(7, -1);
        tick();
        checkOutput("trunc_err", 32'(err), 32'd1);
        checkOutput("trunc_busy", 32'(busy), 32'd0);
        checkOutput("trunc_o_valid", 32'(o_valid), 32'd0);
        ready_mode = 2;
        random_words();
        applyStimulus(N, -1);
        wait_drain(300);
        checkOutput("trunc_err_sticky", 32'(err), 32'd1);

        // x_valid pulses during drain must not disturb data.
        $display("[TB] x_valid during drain");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("clr_err", 32'(err), 32'd0);
        tick();
        random_words();
        applyStimulus(N, -1);
        for (int p = 0; p < 3; p++) begin
            x_valid = 1'b1;
            x_in    = $urandom;
            tick();
            x_valid = 1'b0;
            tick();
        end
        checkOutput("drain_pulse_err", 32'(err), 32'd1);
        wait_drain(300);

        // Reset at capture word 9, then a normal burst.
        $display("[TB] reset mid capture");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        random_words();
        applyStimulus(10, 9);
        checkOutput("midrst_o_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst_o_data", o_data, 32'd0);
        checkOutput("midrst_o_idx", 32'(o_idx), 32'd0);
        checkOutput("midrst_o_last", 32'(o_last), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();
        random_words();
        applyStimulus(N, -1);
        wait_drain(300);

        // Rounding/saturation corner values plus random words.
        $display("[TB] corner values");
        random_words();
        stim_words[0] = 32'h0001_8000;
        stim_words[1] = 32'hFFFE_8000;
        stim_words[2] = 32'h7FFF_FFFF;
        stim_words[3] = 32'h8000_0000;
        stim_words[4] = 32'h0000_7FFF;
        stim_words[5] = 32'hFFFF_8000;
        stim_words[6] = 32'h7FFF_8000;
        stim_words[7] = 32'h8000_7FFF;
        applyStimulus(N, -1);
        wait_drain(300);

        // A few back-to-back random bursts with random backpressure.
        for (int b = 0; b < 3; b++) begin
            random_words();
            applyStimulus(N, -1);
            wait_drain(300);
        end

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
